// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared types and constants for the multi-cycle data-memory responder.
//   dmem_state_t      : responder FSM state encoding (IDLE, WAIT, DONE)
//   DMEM_WORD_BYTES   : bytes per memory word
//   DMEM_LATENCY_DEF  : default number of wait cycles per access
//   DMEM_DEPTH_DEF    : default number of words in the array
// Optional feature macro used by the design files: DMEM_BYTE_EN_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int DMEM_WORD_BYTES  = 4;
  localparam int DMEM_LATENCY_DEF = 3;
  localparam int DMEM_DEPTH_DEF   = 128;

endpackage

// File: rtl/dmem_array.sv
// dmem_array
//   Word-addressed storage for the data-memory responder. Writes are
//   synchronous with per-byte enables; the read port is combinational and
//   the parent registers the word into its data output.
// Ports:
//   clk_i    in  1    clock
//   we_i     in  1    write strobe (commit edge)
//   be_i     in  4    byte enables for the write
//   addr_i   in  AW   word index
//   wdata_i  in  32   write data
//   rdata_o  out 32   word at addr_i
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_DEF
) (
  input  logic                             clk_i,
  input  logic                             we_i,
  input  logic [DMEM_WORD_BYTES-1:0]       be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0]   addr_i,
  input  logic [31:0]                      wdata_i,
  output logic [31:0]                      rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DMEM_WORD_BYTES; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side end of the MEM-stage load/store interface. Accepts one
//   read or write, holds the pipeline with stall_o for LATENCY wait cycles,
//   commits the access, then pulses valid_o (with err_o on a misaligned or
//   read+write request) for one cycle.
//   Optional byte-enable write port is enabled with `define DMEM_BYTE_EN_EN.
// Ports:
//   clk_i       in  1   clock, rising edge
//   rst_i       in  1   synchronous active-high reset
//   be_i        in  4   byte enables (only with DMEM_BYTE_EN_EN)
//   addr_i      in  32  byte address
//   data_i      in  32  store data
//   MemRead_i   in  1   load request
//   MemWrite_i  in  1   store request
//   data_o      out 32  registered load data
//   stall_o     out 1   pipeline freeze
//   valid_o     out 1   completion pulse
//   err_o       out 1   completion with error (only with valid_o)
//
// state | meaning
// IDLE  | waiting for a request; stall_o follows the request combinationally
// WAIT  | request latched, counting down the access latency
// DONE  | access committed; valid_o high, inputs ignored for one cycle
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_DEF,
  parameter int LATENCY     = DMEM_LATENCY_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]  be_i,
`endif
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        valid_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  dmem_state_t state, state_nxt;

  logic [CW-1:0]  cnt;
  logic [AW-1:0]  idx_q;
  logic [31:0]    wdata_q;
  logic [3:0]     be_q;
  logic           rd_q;
  logic           err_q;
  logic           req;
  logic           bad_req;
  logic           commit;
  logic           array_we;
  logic [31:0]    rdata;
  logic           addr_hi_unused;

  // Upper address bits wrap onto the array and are deliberately dropped.
  assign addr_hi_unused = ^addr_i[31:AW+2];

  assign req     = MemRead_i | MemWrite_i;
  assign bad_req = (addr_i[1:0] != 2'b00) | (MemRead_i & MemWrite_i);
  assign commit  = (state == WAIT) && (cnt == '0);
  // rst_i gates the strobe so a reset landing on the commit edge drops the write.
  assign array_we = commit & ~rd_q & ~err_q & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      data_o  <= '0;
    end else begin
      if (state == IDLE && req) begin
        cnt     <= CNT_LOAD;
        idx_q   <= addr_i[AW+1:2];
        wdata_q <= data_i;
`ifdef DMEM_BYTE_EN_EN
        be_q    <= be_i;
`else
        be_q    <= 4'hF;
`endif
        // Read+write together is flagged as an error and behaves like a read.
        rd_q    <= MemRead_i;
        err_q   <= bad_req;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (commit && rd_q) data_o <= err_q ? 32'h0 : rdata;
    end
  end

  assign stall_o = ((state == IDLE) && req) || (state == WAIT);
  assign valid_o = (state == DONE);
  assign err_o   = (state == DONE) && err_q;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (array_we),
    .be_i    (be_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Directed bench for dmem_responder. Each request pushes its expected
//   completion (data_o, err_o) from a reference memory model into a queue;
//   the completion is popped and compared when valid_o is seen.
module tb_dmem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 128;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        valid_o;
  logic        err_o;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  be_i;
`endif

  always #5 clk_i = ~clk_i;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
`ifdef DMEM_BYTE_EN_EN
    .be_i       (be_i),
`endif
    .addr_i     (addr_i),
    .data_i     (data_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .data_o     (data_o),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .err_o      (err_o)
  );

  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_data = 32'h0;
  exp_t        sb[$];
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, what, obs, exp);
  endtask

  // Caller is positioned just after a rising edge; the request is first
  // presented in this cycle.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    int   idx;
    logic err;
    logic [3:0] eb;
    err = (a[1:0] != 2'b00) || (rd && wr);
    idx = int'((a >> 2) & (DEPTH - 1));
`ifdef DMEM_BYTE_EN_EN
    eb = be;
`else
    eb = 4'hF;
`endif
    if (rd) last_data = err ? 32'h0 : model_mem[idx];
    else if (!err) begin
      for (int b = 0; b < 4; b++)
        if (eb[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
    e.data = last_data;
    e.err  = err;
    sb.push_back(e);
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    data_i     = d;
`ifdef DMEM_BYTE_EN_EN
    be_i       = be;
`endif
  endtask

  // Samples on falling edges until valid_o, counts stall cycles, then
  // returns just after the edge that ends the DONE cycle.
  task automatic collect(input string tag);
    int   stalls;
    bit   seen;
    exp_t e;
    stalls = 0;
    seen   = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_i);
      if (valid_o) seen = 1'b1;
      else if (stall_o) stalls++;
    end
    check(tag, "valid_seen", 32'(seen), 32'd1);
    check(tag, "stall_cycles", stalls, LAT + 1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
    if (seen) begin
      check(tag, "stall_in_done", 32'(stall_o), 32'd0);
      check(tag, "err", 32'(err_o), 32'(e.err));
      check(tag, "data", data_o, e.data);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic release_req(input string tag);
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    @(negedge clk_i);
    check(tag, "idle_stall", 32'(stall_o), 32'd0);
    check(tag, "idle_valid", 32'(valid_o), 32'd0);
    @(posedge clk_i); #1;
  endtask

  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be, input string tag);
    issue(rd, wr, a, d, be);
    collect(tag);
    release_req(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i      = 1'b1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    addr_i     = 32'h0;
    data_i     = 32'h0;
`ifdef DMEM_BYTE_EN_EN
    be_i       = 4'hF;
`endif
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("reset", "data", data_o, 32'h0);
    check("reset", "stall", 32'(stall_o), 32'd0);
    check("reset", "valid", 32'(valid_o), 32'd0);
    check("reset", "err", 32'(err_o), 32'd0);
    @(posedge clk_i); #1;

    xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_10");

    // Read held through DONE: single pulse, then re-accepted in the next IDLE.
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    collect("rd_10_hold");
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    collect("rd_10_again");
    release_req("rd_10_again");

    xfer(1'b0, 1'b1, 32'h00,  32'h11, 4'hF, "wr_00");
    xfer(1'b0, 1'b1, 32'h200, 32'h22, 4'hF, "wr_200_wrap");
    xfer(1'b1, 1'b0, 32'h00,  32'h0,  4'hF, "rd_00");

    xfer(1'b0, 1'b1, 32'h12, 32'h77, 4'hF, "wr_misaligned");
    xfer(1'b1, 1'b0, 32'h10, 32'h0,  4'hF, "rd_10_after_mis");
    xfer(1'b1, 1'b1, 32'h10, 32'h99, 4'hF, "rd_wr_both");
    xfer(1'b1, 1'b0, 32'h10, 32'h0,  4'hF, "rd_10_after_both");
    xfer(1'b1, 1'b0, 32'h13, 32'h0,  4'hF, "rd_misaligned");

    xfer(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, "wr_20");
    xfer(1'b1, 1'b0, 32'h20, 32'h0,        4'hF, "rd_20");

    // Write of 0x55 aborted by reset during its second WAIT cycle.
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b1;
    addr_i     = 32'h20;
    data_i     = 32'h55;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i      = 1'b1;
    MemWrite_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("mid_reset", "data", data_o, 32'h0);
    check("mid_reset", "stall", 32'(stall_o), 32'd0);
    check("mid_reset", "valid", 32'(valid_o), 32'd0);
    check("mid_reset", "err", 32'(err_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i     = 1'b0;
    last_data = 32'h0;
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, "rd_20_after_reset");

`ifdef DMEM_BYTE_EN_EN
    xfer(1'b0, 1'b1, 32'h20, 32'h11223344, 4'b0101, "be_write");
    xfer(1'b1, 1'b0, 32'h20, 32'h0,        4'hF,    "be_read");
    xfer(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, "be_zero");
    xfer(1'b1, 1'b0, 32'h20, 32'h0,        4'hF,    "be_zero_read");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
